seq_detect_moore_param: RTL and testbench
=========================================

// Module: seq_detect_moore_param
// PURPOSE
//  Generic Moore-type serial pattern detector for any fixed bit pattern.
//  Supports overlapping or non-overlapping matching and counts matches.
//  Successor to the hard-coded per-pattern detectors; sits on a 1-bit serial stream behind
//  a sample-valid strobe and flags each complete pattern.
// PARAMETERS
//  PAT_LEN  5         pattern length in bits, legal 2..16
//  PATTERN  5'b11011  pattern; PATTERN[PAT_LEN-1] is the first bit received
//  OVERLAP  1         1 = overlapping detection, 0 = non-overlapping
//  CNT_W    8         match-counter width, legal 1..32
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset (0 = reset)
//  en         in   1      sample strobe; in is consumed only when en=1
//  in         in   1      serial data bit
//  clr_cnt    in   1      synchronous clear of match_cnt
//  out        out  1      Moore detect flag
//  match_cnt  out  CNT_W  saturating count of detections
// BEHAVIOUR
//  - state k = length of matched prefix, 0..PAT_LEN; $clog2(PAT_LEN+1) bits; k=PAT_LEN is DETECT.
//  - Reset (rst=0, async): k=0, out=0, match_cnt=0; a mid-stream reset discards partial progress.
//  - en=0: state, out and match_cnt hold; in is ignored.
//  - en=1, bit b; P[i] = PATTERN[PAT_LEN-1-i]:
//    k<PAT_LEN and b==P[k]          -> k+1
//    k<PAT_LEN and b!=P[k]          -> longest proper suffix of P[0..k-1],b that is a prefix of P
//    k==PAT_LEN, OVERLAP=1          -> same fallback rule applied to P,b (KMP failure)
//    k==PAT_LEN, OVERLAP=0          -> restart: next = (b==P[0]) ? 1 : 0
//  - Compute the fallback table at elaboration with a constant function; no runtime search.
//  - out = (k==PAT_LEN): a decode of the state register only (Moore, no path from in).
//    out is high for the cycle after the edge that samples the last pattern bit.
//    It stays high while en=0.
//  - match_cnt increments on each en=1 edge whose next state is DETECT, including DETECT->DETECT.
//  - match_cnt saturates at 2^CNT_W-1 and does not wrap.
//  - clr_cnt=1 with no increment -> 0.
//  - clr_cnt=1 with a same-cycle increment -> 1, so the match event is not lost.
//  - Check for PAT_LEN 11011: k=5, b=0 -> 3; k=5, b=1 -> 2; k=2, b=1 -> 2.
// CONFIGURATION
//  SEQ_DETECT_MATCH_CNT_EN
//    defined:   match counter and clr_cnt logic are built as specified.
//    undefined: match_cnt is tied to 0, clr_cnt is ignored, no counter flops;
//               out and state behaviour are identical.
// TESTING
//  1 Defaults, en=1, in=1,1,0,1,1,0,1,1 -> out=1 after bits 5 and 8 only; match_cnt=2.
//  2 OVERLAP=0, same stream -> out=1 after bit 5 only; state after bit 8 = 2; match_cnt=1.
//  3 Defaults, in=1,1,0 with en=1, then en=0 for 4 cycles with in toggling,
//    then en=1 with in=1,1 -> one detection; state and out hold during en=0.
//  4 rst=0 asserted asynchronously mid-edge after in=1,1,0,1, then released; next bit in=1
//    -> k=0 immediately on rst=0, out stays 0; k=1 after that bit.
//  5 PAT_LEN=3, PATTERN=3'b101, CNT_W=2, stream 1010101010 -> detections after bits 3,5,7,9;
//    match_cnt saturates at 3.
//    Then clr_cnt=1 with in=1 completing a match -> match_cnt=1.
//  6 Macro undefined, run test 1 -> out pattern unchanged; match_cnt=0 throughout.

Source files
------------

// File: rtl/seq_detect_moore_param.sv
// Moore serial pattern detector for an arbitrary PAT_LEN-bit pattern, overlapping or not.
// Define SEQ_DETECT_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detect_moore_param #(
  parameter int unsigned        PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int unsigned   KW     = $clog2(PAT_LEN + 1);
  localparam int unsigned   TW     = (PAT_LEN + 1) * 2 * KW;
  localparam logic [KW-1:0] DETECT = KW'(PAT_LEN);

  // P[i]: i-th bit received, MSB of PATTERN first
  function automatic logic pbit(input int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction

  // Next-state table indexed by {k, b}; entry (k*2+b) holds the next k.
  function automatic logic [TW-1:0] build_tbl();
    logic [TW-1:0]    t;
    logic [PAT_LEN:0] s;
    int               nxt;
    bit               ok;
    t = '0;
    s = '0;
    for (int k = 0; k <= int'(PAT_LEN); k++) begin
      for (int b = 0; b < 2; b++) begin
        nxt = 0;
        if (k < int'(PAT_LEN) && (b[0] == pbit(k))) begin
          nxt = k + 1;
        end else if (k == int'(PAT_LEN) && !OVERLAP) begin
          nxt = (b[0] == pbit(0)) ? 1 : 0;
        end else begin
          // s = P[0..k-1],b ; keep the longest proper suffix that is a prefix of P
          for (int i = 0; i <= int'(PAT_LEN); i++) begin
            if (i < k) s[i] = pbit(i);
            else       s[i] = b[0];
          end
          for (int j = 1; j <= k; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++)
              if (s[k+1-j+i] != pbit(i)) ok = 1'b0;
            if (ok) nxt = j;
          end
        end
        t[(k*2+b)*KW +: KW] = nxt[KW-1:0];
      end
    end
    return t;
  endfunction

  localparam logic [TW-1:0] NXT_TBL = build_tbl();

  logic [KW-1:0] k_q, k_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) k_q <= '0;
    else      k_q <= k_d;
  end

  always_comb begin
    k_d = k_q;
    if (en) begin
      k_d = '0;
      for (int s = 0; s <= int'(PAT_LEN); s++)
        if (k_q == s[KW-1:0]) k_d = NXT_TBL[(s*2 + int'(in))*KW +: KW];
    end
  end

  assign out = (k_q == DETECT);

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // A clear coinciding with a match leaves 1 so that match is still counted
  always_comb begin
    inc   = en && (k_d == DETECT);
    cnt_d = cnt_q;
    if (clr_cnt)                     cnt_d = inc ? CNT_W'(1) : '0;
    else if (inc && (cnt_q != '1))   cnt_d = cnt_q + CNT_W'(1);
  end

  assign match_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Bench for seq_detect_moore_param: three configurations driven by one stream,
// checked against constant tables, hand sequences and a suffix-matching reference model.
module tb_seq_detect_moore_param;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, in, clr_cnt;
  logic out_a, out_b, out_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  seq_detect_moore_param u_a (
    .clk(clk), .rst(rst), .en(en), .in(in), .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a));
  seq_detect_moore_param #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .in(in), .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b));
  seq_detect_moore_param #(.PAT_LEN(3), .PATTERN(3'b101), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .in(in), .clr_cnt(clr_cnt), .out(out_c), .match_cnt(cnt_c));

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: state = longest suffix of the bits seen (since last detect when
  // non-overlapping) that equals a prefix of the pattern
  int          m_plen [3] = '{5, 5, 3};
  logic [15:0] m_pat  [3] = '{16'h1B, 16'h1B, 16'h5};
  bit          m_ovl  [3] = '{1'b1, 1'b0, 1'b1};
  longint      m_cmax [3] = '{255, 255, 3};
  logic [31:0] m_hist [3];
  int          m_hlen [3];
  int          m_k    [3];
  longint      m_cnt  [3];

  function automatic int longest(input int plen, input logic [15:0] pat,
                                 input logic [31:0] h, input int hlen);
    int best = 0;
    for (int j = 1; j <= plen; j++)
      if (j <= hlen && ((h & ((32'd1 << j) - 32'd1)) == (32'(pat) >> (plen - j)))) best = j;
    return best;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_hist[d] = '0; m_hlen[d] = 0; m_k[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit b, input bit c);
    bit inc;
    for (int d = 0; d < 3; d++) begin
      inc = 1'b0;
      if (e) begin
        m_hist[d] = {m_hist[d][30:0], b};
        if (m_hlen[d] < m_plen[d]) m_hlen[d]++;
        m_k[d] = longest(m_plen[d], m_pat[d], m_hist[d], m_hlen[d]);
        inc = (m_k[d] == m_plen[d]);
        if (inc && !m_ovl[d]) m_hlen[d] = 0;
      end
      if (c)                                m_cnt[d] = inc ? 1 : 0;
      else if (inc && m_cnt[d] < m_cmax[d]) m_cnt[d]++;
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.out"}, out_a, m_k[0] == 5);
    chk({tag, " a.k"},   int'(u_a.k_q), m_k[0]);
    chk({tag, " a.cnt"}, cnt_a, CNT_ON ? m_cnt[0] : 0);
    chk({tag, " b.out"}, out_b, m_k[1] == 5);
    chk({tag, " b.k"},   int'(u_b.k_q), m_k[1]);
    chk({tag, " b.cnt"}, cnt_b, CNT_ON ? m_cnt[1] : 0);
    chk({tag, " c.out"}, out_c, m_k[2] == 3);
    chk({tag, " c.k"},   int'(u_c.k_q), m_k[2]);
    chk({tag, " c.cnt"}, cnt_c, CNT_ON ? m_cnt[2] : 0);
  endtask

  task automatic step(input bit e, input bit b, input bit c);
    en = e; in = b; clr_cnt = c;
    @(posedge clk);
    model_step(e, b, c);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  typedef struct {
    bit en; bit in;
    bit oa; int ka; int ca;
    bit ob; int kb; int cb;
  } vec_t;
  vec_t tbl [8];

  initial begin
    // stream 1,1,0,1,1,0,1,1 : overlapping (a) vs non-overlapping (b)
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 1, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 2, 0, 1'b0, 2, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 3, 0, 1'b0, 3, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 4, 0, 1'b0, 4, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 5, 1, 1'b1, 5, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 3, 1, 1'b0, 0, 1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 4, 1, 1'b0, 1, 1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 5, 2, 1'b0, 2, 1};

    rst = 1'b0; en = 1'b0; in = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #1 check_all("reset");
    do_reset();
    check_all("post-reset");

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].in, 1'b0);
      chk($sformatf("tbl%0d a.out", i), out_a, tbl[i].oa);
      chk($sformatf("tbl%0d a.k", i),   int'(u_a.k_q), tbl[i].ka);
      chk($sformatf("tbl%0d a.cnt", i), cnt_a, CNT_ON ? tbl[i].ca : 0);
      chk($sformatf("tbl%0d b.out", i), out_b, tbl[i].ob);
      chk($sformatf("tbl%0d b.k", i),   int'(u_b.k_q), tbl[i].kb);
      chk($sformatf("tbl%0d b.cnt", i), cnt_b, CNT_ON ? tbl[i].cb : 0);
    end

    // en=0 holds state while in toggles
    do_reset();
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, i[0], 0);
      chk($sformatf("hold%0d a.k", i), int'(u_a.k_q), 3);
      chk($sformatf("hold%0d a.out", i), out_a, 0);
    end
    step(1, 1, 0); step(1, 1, 0);
    chk("hold-done a.out", out_a, 1);
    chk("hold-done a.cnt", cnt_a, CNT_ON ? 1 : 0);
    step(0, 0, 0); step(0, 1, 0);
    chk("detect-hold a.out", out_a, 1);
    chk("detect-hold a.cnt", cnt_a, CNT_ON ? 1 : 0);
    check_all("hold");

    // asynchronous reset between edges discards partial progress
    do_reset();
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    chk("pre-arst a.k", int'(u_a.k_q), 4);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst a.k", int'(u_a.k_q), 0);
    chk("arst a.out", out_a, 0);
    @(posedge clk); #1;
    chk("arst-held a.k", int'(u_a.k_q), 0);
    #3 rst = 1'b1;
    step(1, 1, 0);
    chk("arst-after a.k", int'(u_a.k_q), 1);
    chk("arst-after a.out", out_a, 0);

    // 101 detector, 2-bit counter saturation, clear with coincident match
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1, i[0], 0);
      chk($sformatf("p3 bit%0d out", i), out_c, (i >= 3 && i[0]) ? 1 : 0);
      chk($sformatf("p3 bit%0d cnt", i), cnt_c, CNT_ON ? ((i < 3) ? 0 : (i < 5) ? 1 : (i < 7) ? 2 : 3) : 0);
    end
    step(1, 1, 1);
    chk("p3 clr+match out", out_c, 1);
    chk("p3 clr+match cnt", cnt_c, CNT_ON ? 1 : 0);
    step(1, 0, 1);
    chk("p3 clr cnt", cnt_c, 0);
    check_all("p3");

    // random stream against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
      end
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
